jk_cmd_sequencer: RTL
=====================

// Module: jk_cmd_sequencer
// PURPOSE
//   Upstream driver for the jk flip-flop stage; its j/k outputs wire straight to the flop's j/k.
//   Accepts SET/RESET/HOLD/TOGGLE commands over a valid/ready handshake.
//   Holds each command's j/k pair for a programmable number of clock edges.
//   Then checks the flop's q/qb against an internal shadow model and reports pass/fail per command.
// PARAMETERS
//   LEN_W   4   width of cmd_len (edges per command, 1..2**LEN_W-1; 0 treated as 1)
//   ERR_W   8   width of saturating error counter err_cnt
// PORTS
//   clk        in   1       system clock; all state changes on rising edge
//   rst        in   1       synchronous, active-high reset
//   cmd_valid  in   1       command present
//   cmd_ready  out  1       block can accept a command (high only in IDLE)
//   cmd        in   2       00 HOLD (j0k0), 01 RESET (j0k1), 10 SET (j1k0), 11 TOGGLE (j1k1)
//   cmd_len    in   LEN_W   number of clk edges the j/k pair is applied
//   j          out  1       to flop j; registered
//   k          out  1       to flop k; registered
//   q_in       in   1       flop q
//   qb_in      in   1       flop qb
//   done       out  1       one-cycle pulse: command finished, result valid
//   fail       out  1       valid with done: 1 = q/qb mismatch vs shadow
//   checked    out  1       valid with done: 0 = shadow unknown, compare skipped
//   err_cnt    out  ERR_W   saturating count of fail pulses
// BEHAVIOUR
//   Reset values: state=IDLE, j=0, k=0, cmd_ready=1, done=0, fail=0, checked=0, err_cnt=0, shadow_vld=0.
//   States: IDLE -> DRIVE -> CHECK -> IDLE.
//   IDLE:
//     - cmd_ready=1; j=k=0.
//     - Handshake: a command is accepted on an edge with cmd_valid&&cmd_ready.
//     - On accept: latch cmd; latch len=(cmd_len==0)?1:cmd_len; load j/k from cmd; go to DRIVE.
//   DRIVE:
//     - j/k held constant for exactly len cycles; the flop samples them on each of those len edges.
//     - A down-counter tracks the edges; on the edge ending the last DRIVE cycle: j=k=0, go to CHECK.
//   CHECK:
//     - Lasts one cycle; j=k=0, so the flop holds.
//     - On the edge ending CHECK, q_in/qb_in are sampled and compared to the shadow.
//   Result and latency:
//     - Accept edge at cycle T. DRIVE occupies T+1..T+len, CHECK occupies T+len+1.
//     - done/fail/checked are high during T+len+2, which is IDLE again. cmd_ready is already 1 in that cycle.
//     - Back-to-back commands are therefore accepted at most every len+2 cycles.
//   Shadow model (updated on the edge ending CHECK, from the latched cmd and len):
//     - SET: shadow=1, shadow_vld=1.
//     - RESET: shadow=0, shadow_vld=1.
//     - HOLD: unchanged.
//     - TOGGLE: shadow ^= len[0].
//   Compare:
//     - checked = shadow_vld as it stands after the update.
//     - fail = checked && ((q_in != shadow) || (qb_in != ~shadow)).
//     - Compare is skipped while the flop state is unknown: it has no reset, so HOLD/TOGGLE before the first SET/RESET report checked=0, fail=0.
//   err_cnt:
//     - Increments on each fail pulse.
//     - Saturates at 2**ERR_W-1 and does not wrap.
//   Handshake rules:
//     - cmd/cmd_len changes while cmd_ready=0 are ignored.
//     - cmd_valid is sampled only in IDLE.
//   rst during any state (including mid-DRIVE):
//     - Next cycle is IDLE with j=k=0 and no done pulse.
//     - shadow_vld=0 and err_cnt=0; the partial command is discarded.
// TESTING
//   1. rst 2 cycles; TOGGLE len=1 -> done at T+3, checked=0, fail=0, err_cnt=0.
//   2. SET len=1 -> j=1,k=0 for 1 cycle; done at T+3, q_in=1, checked=1, fail=0.
//   3. TOGGLE len=3 after SET -> j=k=1 for 3 cycles; done at T+5, q=0, fail=0.
//      Then HOLD len=5 -> q stays 0, fail=0.
//   4. RESET len=0 (treated as 1) -> j=0,k=1 for 1 cycle.
//      Bench forces q_in=1 -> fail=1, err_cnt=1; repeat 300x with ERR_W=8 -> err_cnt saturates at 255.
//   5. cmd_valid held high with alternating SET/RESET len=2 -> accepts exactly every 4 cycles.
//      cmd_ready low during DRIVE/CHECK; q alternates 1,0,1 with fail=0.
//   6. rst asserted in the 2nd DRIVE cycle of TOGGLE len=6 -> next cycle j=k=0, cmd_ready=1.
//      No done pulse, err_cnt=0; following HOLD reports checked=0.

Source files
------------

// File: rtl/jk_cmd_sequencer_if.sv
// Command/result bundle between a command source and jk_cmd_sequencer.
// The master issues commands and observes results; the slave is the sequencer.
interface jk_cmd_sequencer_if #(
    parameter int LEN_W = 4,
    parameter int ERR_W = 8
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [1:0]       cmd;
    logic [LEN_W-1:0] cmd_len;
    logic             done;
    logic             fail;
    logic             checked;
    logic [ERR_W-1:0] err_cnt;

    modport master (
        output cmd_valid, cmd, cmd_len,
        input  cmd_ready, done, fail, checked, err_cnt
    );

    modport slave (
        input  cmd_valid, cmd, cmd_len,
        output cmd_ready, done, fail, checked, err_cnt
    );
endinterface

// File: rtl/jk_cmd_sequencer.sv
// Drives j/k of an external JK flip-flop for a programmable number of edges per
// command, then compares the flop's q/qb against an internal shadow of what the
// flop should hold, reporting one done/fail/checked pulse per command.
module jk_cmd_sequencer #(
    parameter int LEN_W = 4,
    parameter int ERR_W = 8
) (
    input  logic                clk,
    input  logic                rst,
    jk_cmd_sequencer_if.slave   bus,
    output logic                j,
    output logic                k,
    input  logic                q_in,
    input  logic                qb_in
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        CHECK = 2'd2
    } state_t;

    localparam logic [1:0] CMD_RESET  = 2'b01;
    localparam logic [1:0] CMD_SET    = 2'b10;
    localparam logic [1:0] CMD_TOGGLE = 2'b11;

    state_t           state_q, state_d;
    logic [1:0]       cmd_q, cmd_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [LEN_W-1:0] cnt_q, cnt_d;
    logic             j_q, j_d;
    logic             k_q, k_d;
    logic             done_q, done_d;
    logic             fail_q, fail_d;
    logic             checked_q, checked_d;
    logic [ERR_W-1:0] err_q, err_d;
    logic             shadow_q, shadow_d;
    logic             shadow_vld_q, shadow_vld_d;

    // State register: everything returns to its idle value on reset, which also
    // forgets the shadow because the flop itself has no reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            cmd_q        <= '0;
            len_q        <= '0;
            cnt_q        <= '0;
            j_q          <= 1'b0;
            k_q          <= 1'b0;
            done_q       <= 1'b0;
            fail_q       <= 1'b0;
            checked_q    <= 1'b0;
            err_q        <= '0;
            shadow_q     <= 1'b0;
            shadow_vld_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cmd_q        <= cmd_d;
            len_q        <= len_d;
            cnt_q        <= cnt_d;
            j_q          <= j_d;
            k_q          <= k_d;
            done_q       <= done_d;
            fail_q       <= fail_d;
            checked_q    <= checked_d;
            err_q        <= err_d;
            shadow_q     <= shadow_d;
            shadow_vld_q <= shadow_vld_d;
        end
    end

    // Next-state logic: accept in IDLE, hold j/k for len edges in DRIVE, let the
    // flop settle with j=k=0 for one CHECK cycle, then update shadow and compare.
    always_comb begin
        state_d      = state_q;
        cmd_d        = cmd_q;
        len_d        = len_q;
        cnt_d        = cnt_q;
        j_d          = j_q;
        k_d          = k_q;
        done_d       = 1'b0;
        fail_d       = 1'b0;
        checked_d    = 1'b0;
        err_d        = err_q;
        shadow_d     = shadow_q;
        shadow_vld_d = shadow_vld_q;

        case (state_q)
            IDLE: begin
                j_d = 1'b0;
                k_d = 1'b0;
                if (bus.cmd_valid) begin
                    cmd_d   = bus.cmd;
                    // A zero length would never reach the flop; run it as one edge.
                    len_d   = (bus.cmd_len == '0) ? LEN_W'(1) : bus.cmd_len;
                    cnt_d   = len_d;
                    j_d     = bus.cmd[1];
                    k_d     = bus.cmd[0];
                    state_d = DRIVE;
                end
            end
            DRIVE: begin
                if (cnt_q == LEN_W'(1)) begin
                    j_d     = 1'b0;
                    k_d     = 1'b0;
                    state_d = CHECK;
                end else begin
                    cnt_d = cnt_q - LEN_W'(1);
                end
            end
            CHECK: begin
                j_d = 1'b0;
                k_d = 1'b0;
                case (cmd_q)
                    CMD_SET: begin
                        shadow_d     = 1'b1;
                        shadow_vld_d = 1'b1;
                    end
                    CMD_RESET: begin
                        shadow_d     = 1'b0;
                        shadow_vld_d = 1'b1;
                    end
                    // An even number of toggles leaves the flop where it was.
                    CMD_TOGGLE: shadow_d = shadow_q ^ len_q[0];
                    default: ;
                endcase
                checked_d = shadow_vld_d;
                fail_d    = shadow_vld_d && ((q_in != shadow_d) || (qb_in != ~shadow_d));
                done_d    = 1'b1;
                if (fail_d && (err_q != {ERR_W{1'b1}})) begin
                    err_d = err_q + ERR_W'(1);
                end
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.cmd_ready = (state_q == IDLE);
    assign bus.done      = done_q;
    assign bus.fail      = fail_q;
    assign bus.checked   = checked_q;
    assign bus.err_cnt   = err_q;
    assign j             = j_q;
    assign k             = k_q;

endmodule
